// File: rtl/dpwm_comparador_tm.sv
// Duty comparator stage of the progressive DPWM: double-buffered duty setpoint,
// complementary high/low-side drive with dead time between every side change.
module dpwm_comparador_tm #(
    parameter int CUENTA_MAX = 1000,
    parameter int DT_CICLOS  = 1
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [9:0] cuenta,
    input  logic       enable,
    input  logic [9:0] duty,
    input  logic       duty_load,
    output logic       pwm_h,
    output logic       pwm_l,
    output logic [9:0] duty_activo,
    output logic       periodo_fin,
    output logic       duty_err
);

    // state   | meaning
    // APAGADO | disabled, both outputs low
    // MUERTO  | dead time running, both outputs low
    // ALTO    | high side on
    // BAJO    | low side on
    typedef enum logic [1:0] {APAGADO, MUERTO, ALTO, BAJO} estado_t;

    localparam logic [9:0] CMAX   = 10'(CUENTA_MAX);
    localparam logic [3:0] DT_INI = 4'(DT_CICLOS - 1);

    estado_t    estado;
    logic [3:0] dt_cnt;
    logic [9:0] duty_pend;
    logic       pend_valid;
    logic       fin;
    logic       req;
    logic       satura;

    assign fin    = (cuenta == CMAX);
    assign req    = enable && (cuenta < duty_activo);
    assign satura = (duty > CMAX);

    // A load coinciding with the wrap edge transfers the old pending value and stays pending.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            duty_pend   <= '0;
            pend_valid  <= 1'b0;
            duty_activo <= '0;
            periodo_fin <= 1'b0;
            duty_err    <= 1'b0;
        end else begin
            periodo_fin <= fin;
            if (fin && pend_valid) begin
                duty_activo <= duty_pend;
            end
            if (duty_load) begin
                duty_pend  <= satura ? CMAX : duty;
                pend_valid <= 1'b1;
                duty_err   <= satura;
            end else begin
                duty_err <= 1'b0;
                if (fin) begin
                    pend_valid <= 1'b0;
                end
            end
        end
    end

    // Dead-time timer counts down from DT_CICLOS-1; the decision is taken at terminal count.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            estado <= APAGADO;
            dt_cnt <= '0;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
        end else if (!enable) begin
            estado <= APAGADO;
            pwm_h  <= 1'b0;
            pwm_l  <= 1'b0;
        end else begin
            case (estado)
                APAGADO: begin
                    estado <= MUERTO;
                    dt_cnt <= DT_INI;
                    pwm_h  <= 1'b0;
                    pwm_l  <= 1'b0;
                end
                MUERTO: begin
                    if (dt_cnt == 4'd0) begin
                        if (req) begin
                            estado <= ALTO;
                            pwm_h  <= 1'b1;
                            pwm_l  <= 1'b0;
                        end else begin
                            estado <= BAJO;
                            pwm_h  <= 1'b0;
                            pwm_l  <= 1'b1;
                        end
                    end else begin
                        dt_cnt <= dt_cnt - 4'd1;
                    end
                end
                ALTO: begin
                    if (!req) begin
                        estado <= MUERTO;
                        dt_cnt <= DT_INI;
                        pwm_h  <= 1'b0;
                        pwm_l  <= 1'b0;
                    end
                end
                BAJO: begin
                    if (req) begin
                        estado <= MUERTO;
                        dt_cnt <= DT_INI;
                        pwm_h  <= 1'b0;
                        pwm_l  <= 1'b0;
                    end
                end
                default: begin
                    estado <= APAGADO;
                    pwm_h  <= 1'b0;
                    pwm_l  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpwm_comparador_tm.sv
// Bench for dpwm_comparador_tm: directed vector table, multi-cycle corner sequences
// and a randomized run against a timeline-level reference model.
module tb_dpwm_comparador_tm;

    localparam int CMAX = 1000;
    localparam int DT   = 1;

    logic       CLK = 1'b0;
    logic       reset;
    logic [9:0] cuenta;
    logic       enable;
    logic [9:0] duty;
    logic       duty_load;
    logic       pwm_h;
    logic       pwm_l;
    logic [9:0] duty_activo;
    logic       periodo_fin;
    logic       duty_err;

    dpwm_comparador_tm #(.CUENTA_MAX(CMAX), .DT_CICLOS(DT)) dut (
        .CLK(CLK), .reset(reset), .cuenta(cuenta), .enable(enable), .duty(duty),
        .duty_load(duty_load), .pwm_h(pwm_h), .pwm_l(pwm_l), .duty_activo(duty_activo),
        .periodo_fin(periodo_fin), .duty_err(duty_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int idx   = 0;

    // reference model: duty buffering plus output timeline (on / dead cycles left / side)
    int m_pend, m_pv, m_act, m_fin, m_err;
    int m_on, m_dead, m_side;

    typedef struct {
        int c; int en; int d; int ld;
        int h; int l; int act; int fin; int err;
    } vec_t;
    vec_t vec [14];

    task automatic check(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pend = 0; m_pv = 0; m_act = 0; m_fin = 0; m_err = 0;
        m_on = 0; m_dead = 0; m_side = 0;
    endfunction

    task automatic model_step();
        int c;
        int d;
        int rq;
        c  = int'(cuenta);
        d  = int'(duty);
        rq = (enable && c < m_act) ? 1 : 0;
        if (!enable) m_on = 0;
        else if (m_on == 0) begin m_on = 1; m_dead = DT; end
        else if (m_dead > 0) begin
            m_dead--;
            if (m_dead == 0) m_side = rq;
        end else if (rq != m_side) m_dead = DT;
        m_fin = (c == CMAX) ? 1 : 0;
        if (m_fin == 1 && m_pv == 1) m_act = m_pend;
        if (duty_load) begin
            m_pend = (d > CMAX) ? CMAX : d;
            m_pv   = 1;
            m_err  = (d > CMAX) ? 1 : 0;
        end else begin
            m_err = 0;
            if (m_fin == 1) m_pv = 0;
        end
    endtask

    task automatic chk_model();
        check("model_pwm_h", pwm_h, (m_on == 1 && m_dead == 0 && m_side == 1) ? 1 : 0);
        check("model_pwm_l", pwm_l, (m_on == 1 && m_dead == 0 && m_side == 0) ? 1 : 0);
        check("model_duty_activo", duty_activo, m_act);
        check("model_periodo_fin", periodo_fin, m_fin);
        check("model_duty_err", duty_err, m_err);
        check("no_overlap", pwm_h & pwm_l, 0);
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk_model();
    endtask

    task automatic step_cnt();
        cuenta = 10'(idx * 50);
        tick();
        idx = (idx == 20) ? 0 : idx + 1;
    endtask

    task automatic load_step(input int d);
        duty = 10'(d);
        duty_load = 1'b1;
        step_cnt();
        duty_load = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 21 && idx != target; i++) step_cnt();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge CLK);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int ch, cl, cf, hl;
        reset = 1'b1; cuenta = '0; enable = 1'b0; duty = '0; duty_load = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_pwm_h", pwm_h, 0);
        check("reset_pwm_l", pwm_l, 0);
        check("reset_duty_activo", duty_activo, 0);
        check("reset_periodo_fin", periodo_fin, 0);
        check("reset_duty_err", duty_err, 0);
        reset = 1'b0;

        // directed vector table, DT=1
        vec[0]  = '{1000, 0,  500, 1,  0, 0,    0, 1, 0};
        vec[1]  = '{1000, 0,  500, 0,  0, 0,  500, 1, 0};
        vec[2]  = '{   0, 1,  500, 0,  0, 0,  500, 0, 0};
        vec[3]  = '{  50, 1,  500, 0,  1, 0,  500, 0, 0};
        vec[4]  = '{ 450, 1,  500, 0,  1, 0,  500, 0, 0};
        vec[5]  = '{ 500, 1,  500, 0,  0, 0,  500, 0, 0};
        vec[6]  = '{ 550, 1,  500, 0,  0, 1,  500, 0, 0};
        vec[7]  = '{1023, 1, 1023, 1,  0, 1,  500, 0, 1};
        vec[8]  = '{1000, 1, 1023, 0,  0, 1, 1000, 1, 0};
        vec[9]  = '{   0, 1, 1023, 0,  0, 0, 1000, 0, 0};
        vec[10] = '{   0, 0, 1023, 0,  0, 0, 1000, 0, 0};
        vec[11] = '{   0, 1, 1023, 0,  0, 0, 1000, 0, 0};
        vec[12] = '{ 100, 1, 1023, 0,  1, 0, 1000, 0, 0};
        vec[13] = '{ 100, 0, 1023, 0,  0, 0, 1000, 0, 0};
        for (int i = 0; i < 14; i++) begin
            cuenta = 10'(vec[i].c); enable = vec[i].en[0];
            duty = 10'(vec[i].d); duty_load = vec[i].ld[0];
            model_step();
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_pwm_h", i), pwm_h, vec[i].h);
            check($sformatf("vec%0d_pwm_l", i), pwm_l, vec[i].l);
            check($sformatf("vec%0d_duty_activo", i), duty_activo, vec[i].act);
            check($sformatf("vec%0d_periodo_fin", i), periodo_fin, vec[i].fin);
            check($sformatf("vec%0d_duty_err", i), duty_err, vec[i].err);
        end
        duty_load = 1'b0;
        do_reset();

        // steady state, duty 500
        idx = 0; enable = 1'b1;
        load_step(500);
        repeat (42) step_cnt();
        ch = 0; cl = 0; cf = 0;
        repeat (21) begin
            step_cnt();
            ch += int'(pwm_h); cl += int'(pwm_l); cf += int'(periodo_fin);
        end
        check("d500_high_cycles", 32'(ch), 9);
        check("d500_low_cycles", 32'(cl), 10);
        check("d500_fin_pulses", 32'(cf), 1);

        // load 300 mid-period; takes effect only after the wrap
        run_to(8);
        load_step(300);
        run_to(20);
        check("d300_before_wrap", duty_activo, 500);
        step_cnt();
        check("d300_after_wrap", duty_activo, 300);
        ch = 0;
        repeat (21) begin step_cnt(); ch += int'(pwm_h); end
        check("d300_high_cycles", 32'(ch), 5);

        // saturating load
        run_to(4);
        load_step(1023);
        check("sat_err_pulse", duty_err, 1);
        step_cnt();
        check("sat_err_clear", duty_err, 0);
        run_to(0);
        check("sat_activo", duty_activo, 1000);
        repeat (21) step_cnt();
        cl = 0; hl = 0;
        repeat (42) begin step_cnt(); cl += int'(pwm_l); hl += int'(!pwm_h); end
        check("sat_low_side_never", 32'(cl), 0);
        check("sat_high_gap_present", 32'(hl >= 2 && hl <= 4), 1);

        // load coinciding with the wrap edge
        run_to(5);
        load_step(200);
        run_to(20);
        load_step(700);
        check("wrap_load_old", duty_activo, 200);
        run_to(10);
        check("wrap_load_mid", duty_activo, 200);
        run_to(0);
        check("wrap_load_new", duty_activo, 700);

        // disable while ALTO, then re-enable
        begin
            int found = 0;
            for (int i = 0; i < 50 && found == 0; i++) begin
                step_cnt();
                if (pwm_h) found = 1;
            end
            check("dis_found_alto", 32'(found), 1);
        end
        cf = 0;
        enable = 1'b0;
        step_cnt(); cf += int'(periodo_fin);
        check("dis_pwm_h", pwm_h, 0);
        check("dis_pwm_l", pwm_l, 0);
        repeat (4) begin step_cnt(); cf += int'(periodo_fin); end
        enable = 1'b1;
        repeat (DT) begin
            step_cnt(); cf += int'(periodo_fin);
            check("reen_dead", 32'(pwm_h | pwm_l), 0);
        end
        step_cnt(); cf += int'(periodo_fin);
        check("reen_driven", 32'(pwm_h | pwm_l), 1);
        repeat (21 - DT - 6) begin step_cnt(); cf += int'(periodo_fin); end
        check("dis_fin_pulses", 32'(cf), 1);

        // asynchronous reset mid-period while pwm_h is high
        begin
            int found = 0;
            for (int i = 0; i < 50 && found == 0; i++) begin
                step_cnt();
                if (pwm_h) found = 1;
            end
            check("arst_found_alto", 32'(found), 1);
        end
        #2 reset = 1'b1;
        #1;
        check("arst_pwm_h", pwm_h, 0);
        check("arst_pwm_l", pwm_l, 0);
        check("arst_duty_activo", duty_activo, 0);
        check("arst_periodo_fin", periodo_fin, 0);
        check("arst_duty_err", duty_err, 0);
        @(posedge CLK);
        #1;
        reset = 1'b0;
        model_reset();

        // randomized run against the model
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) enable = ~enable;
            else if (r < 6) enable = 1'b1;
            duty_load = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: duty = 10'($urandom_range(0, 20) * 50);
                1: duty = 10'($urandom_range(990, 1023));
                2: duty = 10'($urandom_range(0, 3));
                default: duty = 10'($urandom_range(0, 1023));
            endcase
            if ($urandom_range(0, 63) == 0) begin
                cuenta = 10'($urandom_range(1001, 1023));
                tick();
            end else begin
                step_cnt();
            end
        end
        duty_load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
